// File: rtl/timing_pulse_sequencer.sv
// One-hot timing-pulse train generator with free-run, one-shot and single-step modes,
// stall hold, cycle-complete strobe and a completed-cycle counter.
module timing_pulse_sequencer #(
   parameter int unsigned NUM_PULSES = 12,
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned IDX_W      = $clog2(NUM_PULSES)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            mode,
   input  logic                  run,
   input  logic                  start,
   input  logic                  step,
   input  logic                  stall,
   output logic [NUM_PULSES-1:0] tp,
   output logic [IDX_W-1:0]      index,
   output logic                  busy,
   output logic                  cycle_done,
   output logic [CNT_W-1:0]      cycle_count
);

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_e;

   typedef enum logic [1:0] {
      M_FREE    = 2'b00,
      M_ONESHOT = 2'b01,
      M_STEP    = 2'b10
   } mode_e;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PULSES - 1);

   state_e                  state_q, state_d;
   mode_e                   mode_q, mode_d;
   mode_e                   mode_in;
   logic [NUM_PULSES-1:0]   tp_q, tp_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    launch;
   logic                    advance;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mode_q  <= M_FREE;
         tp_q    <= '0;
         idx_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         tp_q    <= tp_d;
         idx_q   <= idx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      tp_d    = tp_q;
      idx_d   = idx_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      launch  = 1'b0;
      advance = 1'b0;

      // Reserved encoding 11 falls back to free-run
      case (mode)
         2'b01:   mode_in = M_ONESHOT;
         2'b10:   mode_in = M_STEP;
         default: mode_in = M_FREE;
      endcase

      if (!stall) begin
         case (state_q)
            S_IDLE: begin
               case (mode_in)
                  M_ONESHOT: launch = start;
                  M_STEP:    launch = step;
                  default:   launch = run;
               endcase
               if (launch) begin
                  state_d = S_ACTIVE;
                  mode_d  = mode_in;
                  tp_d    = NUM_PULSES'(1);
                  idx_d   = '0;
                  busy_d  = 1'b1;
               end
            end
            default: begin
               advance = (mode_q != M_STEP) || step;
               if (advance) begin
                  if (idx_q == LAST_IDX) begin
                     done_d = 1'b1;
                     cnt_d  = cnt_q + CNT_W'(1);
                     idx_d  = '0;
                     if (mode_q == M_FREE && run) begin
                        tp_d = NUM_PULSES'(1);
                     end else begin
                        state_d = S_IDLE;
                        tp_d    = '0;
                        busy_d  = 1'b0;
                     end
                  end else begin
                     tp_d  = tp_q << 1;
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
         endcase
      end
   end

   assign tp          = tp_q;
   assign index       = idx_q;
   assign busy        = busy_q;
   assign cycle_done  = done_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_timing_pulse_sequencer.sv
// Directed self-checking bench for timing_pulse_sequencer: a 12-pulse/16-bit instance
// and a 2-pulse/2-bit instance for counter wrap and minimum pulse count.
module tb_timing_pulse_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mode;
   logic        run, start, step, stall;
   logic [11:0] tp;
   logic [3:0]  index;
   logic        busy, cycle_done;
   logic [15:0] cycle_count;

   logic        run2;
   logic [1:0]  tp2;
   logic [0:0]  index2;
   logic        busy2, done2;
   logic [1:0]  count2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   timing_pulse_sequencer #(.NUM_PULSES(12), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .run(run), .start(start),
      .step(step), .stall(stall), .tp(tp), .index(index), .busy(busy),
      .cycle_done(cycle_done), .cycle_count(cycle_count)
   );

   timing_pulse_sequencer #(.NUM_PULSES(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .mode(2'b00), .run(run2), .start(1'b0),
      .step(1'b0), .stall(1'b0), .tp(tp2), .index(index2), .busy(busy2),
      .cycle_done(done2), .cycle_count(count2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag, input logic exp_done, input logic [15:0] exp_cnt);
      check({tag, ".tp"}, 32'(tp), 32'h0);
      check({tag, ".index"}, 32'(index), 32'h0);
      check({tag, ".busy"}, 32'(busy), 32'h0);
      check({tag, ".done"}, 32'(cycle_done), 32'(exp_done));
      check({tag, ".count"}, 32'(cycle_count), 32'(exp_cnt));
   endtask

   initial begin
      rst_n = 1'b0; mode = 2'b00; run = 1'b0; start = 1'b0; step = 1'b0; stall = 1'b0;
      run2 = 1'b0;
      tick(); tick();
      check_idle("reset", 1'b0, 16'd0);
      check("reset.tp2", 32'(tp2), 32'h0);

      // Free-run: three full cycles
      rst_n = 1'b1; run = 1'b1;
      tick();
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < 12; p++) begin
            check("fr.tp", 32'(tp), 32'h1 << p);
            check("fr.index", 32'(index), 32'(p));
            check("fr.busy", 32'(busy), 32'h1);
            check("fr.done", 32'(cycle_done), 32'((p == 0 && c > 0) ? 1 : 0));
            check("fr.count", 32'(cycle_count), 32'(c));
            tick();
         end
      end
      check("fr3.tp", 32'(tp), 32'h1);
      check("fr3.done", 32'(cycle_done), 32'h1);
      check("fr3.count", 32'(cycle_count), 32'd3);

      // Free-run stop at tp[4]: cycle completes, no truncation
      for (int i = 0; i < 4; i++) tick();
      check("stop.tp4", 32'(tp), 32'h010);
      run = 1'b0;
      for (int p = 5; p < 12; p++) begin
         tick();
         check("stop.tp", 32'(tp), 32'h1 << p);
         check("stop.done", 32'(cycle_done), 32'h0);
      end
      tick();
      check_idle("stop.end", 1'b1, 16'd4);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("stop.quiet", 1'b0, 16'd4);
      end

      // One-shot with an ignored second start at tp[6]
      mode = 2'b01; start = 1'b1;
      tick();
      start = 1'b0;
      for (int p = 0; p < 12; p++) begin
         check("os.tp", 32'(tp), 32'h1 << p);
         check("os.index", 32'(index), 32'(p));
         start = (p == 6);
         tick();
      end
      start = 1'b0;
      check_idle("os.end", 1'b1, 16'd5);
      tick();
      check_idle("os.quiet", 1'b0, 16'd5);

      // Single-step with stall
      mode = 2'b10; step = 1'b1;
      tick(); tick(); tick();
      step = 1'b0;
      check("ss.tp2", 32'(tp), 32'h004);
      check("ss.idx2", 32'(index), 32'd2);
      tick();
      check("ss.hold", 32'(tp), 32'h004);
      stall = 1'b1; step = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ss.stall.tp", 32'(tp), 32'h004);
         check("ss.stall.idx", 32'(index), 32'd2);
         check("ss.stall.done", 32'(cycle_done), 32'h0);
      end
      stall = 1'b0;
      tick();
      step = 1'b0;
      check("ss.tp3", 32'(tp), 32'h008);
      check("ss.idx3", 32'(index), 32'd3);
      tick();
      check("ss.noadv", 32'(tp), 32'h008);

      // Reset in the middle of a cycle at tp[7]
      step = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      step = 1'b0;
      check("rst.tp7", 32'(tp), 32'h080);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_idle("rst.mid", 1'b0, 16'd0);

      // start with stall in IDLE: no launch, not remembered
      mode = 2'b01; start = 1'b1; stall = 1'b1;
      tick();
      check("ststall.tp", 32'(tp), 32'h0);
      start = 1'b0; stall = 1'b0;
      tick();
      check("ststall.after", 32'(tp), 32'h0);

      // Reserved mode 11 behaves as free-run
      mode = 2'b11; run = 1'b1;
      tick();
      run = 1'b0;
      check("m11.tp", 32'(tp), 32'h1);
      for (int i = 0; i < 12; i++) tick();
      check_idle("m11.end", 1'b1, 16'd1);

      // Two-pulse instance, 2-bit counter wrap
      run2 = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) begin
         check("np2.tp", 32'(tp2), 32'h1 << (k % 2));
         check("np2.index", 32'(index2), 32'(k % 2));
         check("np2.busy", 32'(busy2), 32'h1);
         check("np2.done", 32'(done2), 32'((k % 2 == 0 && k > 0) ? 1 : 0));
         check("np2.count", 32'(count2), 32'((k / 2) % 4));
         tick();
      end
      check("np2.wrap.done", 32'(done2), 32'h1);
      check("np2.wrap.count", 32'(count2), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/timing_pulse_sequencer.md
Name: timing_pulse_sequencer

Overview:
Parametrised successor to the fixed timing-pulse generator. It produces a one-hot train of NUM_PULSES timing pulses that defines the memory-cycle time for the processor datapath. It adds three modes (free-run, one-shot, single-step), a stall input for memory-wait extension, clean stop at a cycle boundary, a cycle-complete strobe and a completed-cycle counter. It sits at the top of the control path and feeds the control-pulse decoder and the memory timing logic.

Parameters:
NUM_PULSES, 12, pulses per memory cycle; must be >= 2.
CNT_W, 16, width of the completed-cycle counter.
IDX_W, $clog2(NUM_PULSES), width of the position index; derived, do not override.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  synchronous active-low reset.
mode  in  2  operating mode: 00 free-run, 01 one-shot, 10 single-step, 11 reserved (treated as 00).
run  in  1  free-run enable (level).
start  in  1  one-shot launch strobe.
step  in  1  single-step advance strobe.
stall  in  1  hold the current position.
tp  out  NUM_PULSES  one-hot timing pulses; all zero when idle.
index  out  IDX_W  binary position of the active pulse; 0 when idle.
busy  out  1  high while any tp bit is high.
cycle_done  out  1  one-cycle strobe after tp[NUM_PULSES-1] retires.
cycle_count  out  CNT_W  number of completed cycles, modulo 2^CNT_W.

Behaviour:
- One clock, one synchronous active-low reset (clk, rst_n); polarity and synchronicity fixed. All outputs registered.
- Reset (rst_n=0 at an edge): tp=0, index=0, busy=0, cycle_done=0, cycle_count=0, state IDLE, latched mode=00. Reset mid-cycle aborts the cycle with no cycle_done and no count increment.
- States: IDLE (tp=0) and ACTIVE (exactly one tp bit high, tp[index]=1). Legal tp values are only one-hot or zero.
- mode is sampled only in IDLE, at the launch edge. Changes while ACTIVE take effect after the return to IDLE.
- stall=1 takes priority over every advance and launch condition. It freezes tp, index, busy and the state. No cycle_done while stalled.
- Launch from IDLE with stall=0:
  - free-run: run=1
  - one-shot: start=1
  - single-step: step=1
  - Result: tp[0]=1 and index=0 after that edge. Latency is 1 clock.
- Advance in ACTIVE with stall=0:
  - free-run and one-shot: advance every clock.
  - single-step: advance only on edges with step=1.
  - Advance moves position p to p+1 for p < NUM_PULSES-1.
- Retire of the last pulse (advance from p=NUM_PULSES-1):
  - cycle_done=1 for exactly the next clock.
  - cycle_count increments by 1 on the same edge; wraps 2^CNT_W-1 -> 0.
  - free-run with run=1: go straight to tp[0] with no idle gap. Back-to-back cycles are exactly NUM_PULSES clocks each.
  - free-run with run=0, one-shot, single-step: go to IDLE.
- Free-run stop: deasserting run mid-cycle never truncates. The cycle completes through tp[NUM_PULSES-1], then the block goes to IDLE.
- start while ACTIVE is ignored and not queued. step in free-run or one-shot is ignored. run in one-shot or single-step is ignored.
- Simultaneous start=1 and stall=1 in IDLE: no launch; start is not remembered.
- index is always consistent with tp in the same cycle. busy = |tp.

Test Plan:
- Reset then free-run: NUM_PULSES=12, mode=00, run=1 -> tp[0] 1 clock after run is sampled; tp walks 0..11 with one bit per clock; cycle_done pulses every 12 clocks; cycle_count reaches 3 after 36 clocks of ACTIVE.
- Free-run stop: deassert run while tp[4]=1 -> tp continues 5..11, then goes to 0; busy=0; exactly one more cycle_done; no further pulses.
- One-shot: mode=01, single start pulse -> exactly 12 pulses, one cycle_done, cycle_count +1, then IDLE. A second start at tp[6] has no effect.
- Single-step with stall: mode=10, 3 step strobes -> tp[2]=1, index=2. Hold stall=1 with step=1 for 5 clocks -> tp frozen at bit 2. Release stall -> advances to 3 on the next step.
- Reset mid-operation: assert rst_n=0 at tp[7] -> next cycle tp=0, index=0, cycle_count=0, cycle_done=0.
- Counter wrap: CNT_W=2, free-run for 5 cycles -> cycle_count sequence 1,2,3,0,1; NUM_PULSES=2 -> tp alternates 01,10 with cycle_done every 2 clocks.
